riscv_crypto_aes_dec_unit: RTL and testbench

Pipelined AES decryption-round unit for the RS5 crypto extension, executing the Zkne/Zknd RV32 instructions aes32dsi and aes32dsmi. It is the decrypt-direction counterpart of the forward S-box datapath. It selects one byte of rs2, passes it through the inverse AES S-box, optionally applies InvMixColumns, rotates the result, and XORs it into rs1. It sits beside the execute stage behind a valid/ready handshake, and the core can flush it.

---
 rtl/riscv_crypto_aes_pkg.sv | 48 ++++
 rtl/riscv_crypto_aes_inv_sbox.sv | 39 +++
 rtl/riscv_crypto_aes_dec_unit.sv | 78 +++++++
 tb/tb_riscv_crypto_aes_dec_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_crypto_aes_pkg.sv
// Shared helpers for the AES decrypt-round unit: GF(2^8) constant multipliers,
// word rotate, S1 stage record and the post-S-box round datapath.
package riscv_crypto_aes_pkg;

    typedef struct packed {
        logic        valid;
        logic        mix;
        logic [1:0]  bs;
        logic [31:0] rs1;
        logic [7:0]  x;
    } s1_t;

    // Multiply by 2 modulo x^8 + x^4 + x^3 + x + 1 (0x11B)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] w, input logic [4:0] amt);
        logic [63:0] d;
        d = {w, w} << amt;
        return d[63:32];
    endfunction

    // InvMixColumns column (optional), rotate into the selected byte lane, fold into rs1
    function automatic logic [31:0] dec_round(input logic mix, input logic [1:0] bs,
                                              input logic [31:0] rs1, input logic [7:0] x);
        logic [31:0] m;
        m = mix ? {gmul_0b(x), gmul_0d(x), gmul_09(x), gmul_0e(x)} : {24'h0, x};
        return rs1 ^ rol32(m, {bs, 3'b000});
    endfunction

endpackage

// File: rtl/riscv_crypto_aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine layer followed by the
// GF(2^8) multiplicative inverse computed as a^254.
module riscv_crypto_aes_inv_sbox
    import riscv_crypto_aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ t;
            t = xtime(t);
        end
        return acc;
    endfunction

    logic [7:0] b;
    logic [7:0] p2, p4, p8, p16, p32, p64, p128;

    always_comb begin
        b    = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        p2   = gf_mul(b, b);
        p4   = gf_mul(p2, p2);
        p8   = gf_mul(p4, p4);
        p16  = gf_mul(p8, p8);
        p32  = gf_mul(p16, p16);
        p64  = gf_mul(p32, p32);
        p128 = gf_mul(p64, p64);
        // 254 = 2+4+8+16+32+64+128; zero maps to zero as AES requires
        y    = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));
    end

endmodule

// File: rtl/riscv_crypto_aes_dec_unit.sv
// aes32dsi / aes32dsmi execution unit with valid/ready handshake and flush.
// RS5_AES_DEC_PIPE_EN adds the S1 register after the inverse S-box (2-cycle latency).
module riscv_crypto_aes_dec_unit
    import riscv_crypto_aes_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        mix_i,
    input  logic [1:0]  bs_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
);

    logic [7:0] sbox_x;

    riscv_crypto_aes_inv_sbox u_inv_sbox (
        .a (rs2_i[{bs_i, 3'b000} +: 8]),
        .y (sbox_x)
    );

`ifdef RS5_AES_DEC_PIPE_EN
    s1_t  s1_q;
    logic s1_adv;
    logic accept;

    assign s1_adv  = !valid_o || ready_i;
    assign ready_o = !flush_i && (!s1_q.valid || s1_adv);
    assign accept  = valid_i && ready_o;
    assign busy_o  = s1_q.valid || valid_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            valid_o  <= 1'b0;
            result_o <= 32'h0;
        end else if (flush_i) begin
            s1_q.valid <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            if (s1_adv) begin
                valid_o <= s1_q.valid;
                if (s1_q.valid) result_o <= dec_round(s1_q.mix, s1_q.bs, s1_q.rs1, s1_q.x);
            end
            // ready_o already folds in whether S1 can move this cycle
            if (ready_o) s1_q.valid <= valid_i;
            if (accept) begin
                s1_q.mix <= mix_i;
                s1_q.bs  <= bs_i;
                s1_q.rs1 <= rs1_i;
                s1_q.x   <= sbox_x;
            end
        end
    end
`else
    assign ready_o = !flush_i && (!valid_o || ready_i);
    assign busy_o  = valid_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_o  <= 1'b0;
            result_o <= 32'h0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (!valid_o || ready_i) begin
            valid_o <= valid_i;
            if (valid_i) result_o <= dec_round(mix_i, bs_i, rs1_i, sbox_x);
        end
    end
`endif

endmodule

// File: tb/tb_riscv_crypto_aes_dec_unit.sv
// Directed self-checking bench for riscv_crypto_aes_dec_unit (either RS5_AES_DEC_PIPE_EN build).
module tb_riscv_crypto_aes_dec_unit;

`ifdef RS5_AES_DEC_PIPE_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic        mix_i;
    logic [1:0]  bs_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    riscv_crypto_aes_dec_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .mix_i    (mix_i),
        .bs_i     (bs_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    // Drives one op with ready_i high; returns its result and cycles from accept to valid_o.
    task automatic issue_op(input logic mix, input logic [1:0] bs, input logic [31:0] rs1,
                            input logic [31:0] rs2, output logic [31:0] res, output int lat);
        int guard;
        @(negedge clk);
        mix_i = mix; bs_i = bs; rs1_i = rs1; rs2_i = rs2;
        valid_i = 1'b1; ready_i = 1'b1;
        guard = 0;
        #1;
        while (!ready_o && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        mix_i = 1'b0; bs_i = 2'd0; rs1_i = 32'h0; rs2_i = 32'h0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        tests_run++;
        if (result_o !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 00000000", result_o); end
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_dsi();
        logic [31:0] res;
        int lat;
        issue_op(1'b0, 2'd0, 32'h0, 32'h0, res, lat);
        tests_run++;
        if (res !== 32'h00000052) begin tests_failed++; $display("FAIL dsi_bs0: got %h expected 00000052", res); end
        tests_run++;
        if (lat !== LAT) begin tests_failed++; $display("FAIL dsi_latency: got %0d expected %0d", lat, LAT); end
        issue_op(1'b0, 2'd3, 32'hFFFFFFFF, 32'h7C000000, res, lat);
        tests_run++;
        if (res !== 32'hFEFFFFFF) begin tests_failed++; $display("FAIL dsi_bs3: got %h expected FEFFFFFF", res); end
        issue_op(1'b0, 2'd2, 32'hA5A5A5A5, 32'h00ED0000, res, lat);
        tests_run++;
        if (res !== 32'hA5F6A5A5) begin tests_failed++; $display("FAIL dsi_bs2: got %h expected A5F6A5A5", res); end
    endtask

    task automatic test_dsmi();
        logic [31:0] res;
        int lat;
        issue_op(1'b1, 2'd0, 32'h0, 32'h0000007C, res, lat);
        tests_run++;
        if (res !== 32'h0B0D090E) begin tests_failed++; $display("FAIL dsmi_bs0: got %h expected 0B0D090E", res); end
        issue_op(1'b1, 2'd1, 32'h0, 32'h00007C00, res, lat);
        tests_run++;
        if (res !== 32'h0D090E0B) begin tests_failed++; $display("FAIL dsmi_bs1: got %h expected 0D090E0B", res); end
        issue_op(1'b1, 2'd3, 32'h0, 32'h77000000, res, lat);
        tests_run++;
        if (res !== 32'h1C161A12) begin tests_failed++; $display("FAIL dsmi_bs3: got %h expected 1C161A12", res); end
        tests_run++;
        if (lat !== LAT) begin tests_failed++; $display("FAIL dsmi_latency: got %0d expected %0d", lat, LAT); end
    endtask

    // 8 ops at full rate, then 4 more while ready_i is held low for cycles 10..12
    task automatic test_back_to_back();
        logic        v_mix [8];
        logic [1:0]  v_bs  [8];
        logic [31:0] v_rs1 [8];
        logic [31:0] v_rs2 [8];
        logic [31:0] v_exp [8];
        logic [31:0] expq[$];
        logic [31:0] prev_res;
        logic        prev_stall, want, exp_rdy;
        int pushed, popped, c, eighth, idx;

        v_mix = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        v_bs  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd1};
        v_rs1 = '{32'h00000000, 32'h11111111, 32'h00000000, 32'h0000FFFF,
                  32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        v_rs2 = '{32'h00000000, 32'h00007C00, 32'h00770000, 32'h16000000,
                  32'h000000ED, 32'h00000077, 32'h007C0000, 32'h00006300};
        v_exp = '{32'h00000052, 32'h11111011, 32'h00020000, 32'hFF00FFFF,
                  32'hA5A5A5F6, 32'h161A121C, 32'hF6F1F4F2, 32'h12345678};

        pushed = 0; popped = 0; c = 0; eighth = -1; idx = 0;
        prev_stall = 1'b0; prev_res = 32'h0;
        while (popped < 12 && c < 60) begin
            @(negedge clk);
            ready_i = !(c >= 10 && c <= 12);
            want = (pushed < 8) ? (c < 8) : (pushed < 12 && c >= 10);
            idx = pushed % 8;
            valid_i = want;
            mix_i = v_mix[idx]; bs_i = v_bs[idx]; rs1_i = v_rs1[idx]; rs2_i = v_rs2[idx];
            #1;
            if (prev_stall) begin
                tests_run++;
                if (valid_o !== 1'b1 || result_o !== prev_res) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got valid=%b result=%h expected valid=1 result=%h", valid_o, result_o, prev_res);
                end
            end
            exp_rdy = ready_i || ((pushed - popped) < CAP);
            tests_run++;
            if (ready_o !== exp_rdy) begin
                tests_failed++;
                $display("FAIL b2b_ready cycle %0d: got %b expected %b", c, ready_o, exp_rdy);
            end
            if (valid_o && ready_i) begin
                tests_run++;
                if (expq.size() == 0 || result_o !== expq[0]) begin
                    tests_failed++;
                    $display("FAIL b2b_result cycle %0d: got %h expected %h", c, result_o,
                             (expq.size() == 0) ? 32'h0 : expq[0]);
                end
                if (expq.size() > 0) void'(expq.pop_front());
                popped++;
                if (popped == 8) eighth = c;
            end
            if (valid_i && ready_o) begin
                expq.push_back(v_exp[idx]);
                pushed++;
            end
            prev_stall = valid_o && !ready_i;
            prev_res   = result_o;
            c++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tests_run++;
        if (popped !== 12 || pushed !== 12) begin
            tests_failed++;
            $display("FAIL b2b_count: got accepted=%0d delivered=%0d expected 12/12", pushed, popped);
        end
        tests_run++;
        if (eighth !== 7 + LAT) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got eighth result at cycle %0d expected %0d", eighth, 7 + LAT);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1;
        mix_i = 1'b0; bs_i = 2'd0; rs1_i = 32'h0; rs2_i = 32'h0000007C;
        @(negedge clk);
        rs2_i = 32'h00000000;
        @(negedge clk);
        flush_i = 1'b1; rs2_i = 32'h00000063;
        #1;
        tests_run++;
        if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %b expected 0", ready_o); end
        tests_run++;
        if (busy_o !== 1'b1 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_prefill: got busy=%b valid=%b expected 1/1", busy_o, valid_o);
        end
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear: got valid=%b busy=%b expected 0/0", valid_o, busy_o);
        end
        @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_accept: got valid=%b busy=%b expected 0/0", valid_o, busy_o);
        end
        issue_op(1'b0, 2'd1, 32'h11111111, 32'h00007C00, res, lat);
        tests_run++;
        if (res !== 32'h11111011) begin tests_failed++; $display("FAIL flush_after_op: got %h expected 11111011", res); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, guard;
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1;
        mix_i = 1'b0; bs_i = 2'd0; rs1_i = 32'hDEADBEEF; rs2_i = 32'h0000007C;
        @(negedge clk);
        valid_i = 1'b0;
        guard = 0;
        while (!valid_o && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (valid_o !== 1'b1 || result_o !== 32'hDEADBEEE) begin
            tests_failed++;
            $display("FAIL arst_prefill: got valid=%b result=%h expected 1/DEADBEEE", valid_o, result_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_clear: got valid=%b result=%h busy=%b expected 0/00000000/0", valid_o, result_o, busy_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ready_i = 1'b1;
        issue_op(1'b0, 2'd0, 32'h0, 32'h0, res, lat);
        tests_run++;
        if (res !== 32'h00000052) begin tests_failed++; $display("FAIL arst_first_op: got %h expected 00000052", res); end
        tests_run++;
        if (lat !== LAT) begin tests_failed++; $display("FAIL arst_latency: got %0d expected %0d", lat, LAT); end
    endtask

    initial begin
        test_reset();
        test_dsi();
        test_dsmi();
        test_back_to_back();
        test_flush();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
